// File: rtl/cat_apb_pkg.sv
// ============================================================================
// Module  : cat_apb_pkg
// Brief   : Shared constants and FSM state type for the cat recognizer APB
//           initiator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cat_apb_pkg;

    localparam int c_AMBA_WORD       = 24;
    localparam int c_AMBA_ADDR_DEPTH = 13;
    localparam int c_LEN_WIDTH       = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        SETUP     = 2'd2,
        ACCESS    = 2'd3
    } apb_state_e;

endpackage

`default_nettype wire

// File: rtl/cat_apb_master.sv
// ============================================================================
// Module  : cat_apb_master
// Brief   : Command/data stream to APB initiator with incrementing bursts,
//           feeding the cat recognizer's slave port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cat_apb_master
    import cat_apb_pkg::*;
#(
    parameter int AMBA_WORD       = c_AMBA_WORD,
    parameter int AMBA_ADDR_DEPTH = c_AMBA_ADDR_DEPTH,
    parameter int LEN_WIDTH       = c_LEN_WIDTH
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       cmd_valid_i,
    output logic                       cmd_ready_o,
    input  logic                       cmd_write_i,
    input  logic [AMBA_ADDR_DEPTH-1:0] cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]       cmd_len_i,
    input  logic                       wd_valid_i,
    output logic                       wd_ready_o,
    input  logic [AMBA_WORD-1:0]       wd_data_i,
    output logic                       rsp_valid_o,
    output logic [AMBA_WORD-1:0]       rsp_rdata_o,
    output logic                       done_o,
    output logic                       psel_o,
    output logic                       penable_o,
    output logic                       pwrite_o,
    output logic [AMBA_ADDR_DEPTH-1:0] paddr_o,
    output logic [AMBA_WORD-1:0]       pwdata_o,
    input  logic [AMBA_WORD-1:0]       prdata_i
);

    apb_state_e                 state_q, state_d;
    logic [AMBA_ADDR_DEPTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]       cnt_q, cnt_d;
    logic                       write_q, write_d;
    logic [AMBA_WORD-1:0]       wdata_q, wdata_d;
    logic [AMBA_WORD-1:0]       rdata_q, rdata_d;
    logic                       rsp_valid_q, rsp_valid_d;
    logic                       done_q, done_d;
    logic                       psel_q, psel_d;
    logic                       penable_q, penable_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            done_q      <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
            done_q      <= done_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        rsp_valid_d = 1'b0;
        done_d      = 1'b0;
        cmd_ready_o = 1'b0;
        wd_ready_o  = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    write_d = cmd_write_i;
                    addr_d  = cmd_addr_i;
                    cnt_d   = cmd_len_i;
                    state_d = cmd_write_i ? WAIT_DATA : SETUP;
                end
            end
            WAIT_DATA: begin
                wd_ready_o = 1'b1;
                if (wd_valid_i) begin
                    wdata_d = wd_data_i;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (!write_q) begin
                    rdata_d     = prdata_i;
                    rsp_valid_d = 1'b1;
                end
                if (cnt_q != '0) begin
                    addr_d = addr_q + 1'b1;
                    cnt_d  = cnt_q - 1'b1;
                    if (write_q) begin
                        // Next beat's data may be taken here to skip WAIT_DATA.
                        wd_ready_o = 1'b1;
                        if (wd_valid_i) begin
                            wdata_d = wd_data_i;
                            state_d = SETUP;
                        end else begin
                            state_d = WAIT_DATA;
                        end
                    end else begin
                        state_d = SETUP;
                    end
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        psel_d    = (state_d == SETUP) || (state_d == ACCESS);
        penable_d = (state_d == ACCESS);
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rdata_q;
    assign done_o      = done_q;
    assign psel_o      = psel_q;
    assign penable_o   = penable_q;
    assign pwrite_o    = write_q;
    assign paddr_o     = addr_q;
    assign pwdata_o    = wdata_q;

endmodule

`default_nettype wire

// File: doc/cat_apb_master.md
# cat_apb_master

APB initiator that drives the cat recognizer's slave port (PSEL/PENABLE/PWRITE/PADDR/PWDATA out, PRDATA in). It converts simple command/data streams from the test controller or on-chip loader into APB transfers, with optional incrementing bursts for loading pixels and weights. It also returns read data from the recognizer's register map. The block is the counterpart of the recognizer's `cat` modport and sits between the image/weight source and the recognizer.

## Interface
- Amba_Word, 24, APB data width
- Amba_Addr_Depth, 13, APB address width
- Len_Width, 8, burst-length field width
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  Amba_Addr_Depth  first beat address
- cmd_len  in  Len_Width  beats minus 1 (0 = single transfer)
- wd_valid  in  1  write data offered
- wd_ready  out  1  write data accepted this cycle
- wd_data  in  Amba_Word  write beat data
- rsp_valid  out  1  one-cycle pulse, read data valid
- rsp_rdata  out  Amba_Word  captured PRDATA
- done  out  1  one-cycle pulse after the last beat of a burst
- PSEL, PENABLE, PWRITE  out  1  APB control
- PADDR  out  Amba_Addr_Depth  APB address
- PWDATA  out  Amba_Word  APB write data
- PRDATA  in  Amba_Word  APB read data

## Operation
- The FSM has four states: IDLE, WAIT_DATA, SETUP, ACCESS.
- **IDLE**
  - cmd_ready=1.
  - On cmd_valid, latch write/addr/len and load beat counter = cmd_len.
  - Next state is WAIT_DATA for a write, SETUP for a read.
- **WAIT_DATA**
  - PSEL=0, wd_ready=1.
  - On wd_valid, register wd_data into PWDATA and go to SETUP.
- **SETUP**
  - PSEL=1, PENABLE=0.
  - PADDR and PWRITE are stable from here through ACCESS.
  - Always go to ACCESS.
- **ACCESS**
  - PSEL=1, PENABLE=1.
  - There is no PREADY, so ACCESS is always exactly one cycle.
  - Read: capture PRDATA into rsp_rdata at the edge that ends ACCESS.
  - If beats remain: PADDR += 1 (modulo 2^Amba_Addr_Depth, wraps to 0), counter -= 1.
    - Read: go to SETUP.
    - Write: wd_ready=1 in ACCESS. If wd_valid, latch the data and go to SETUP; else go to WAIT_DATA (PSEL drops).
  - If this is the last beat: go to IDLE and pulse done.
- wd_ready is 0 outside WAIT_DATA and non-final write ACCESS. Write data offered at any other time is ignored (not consumed).
- rsp_valid has no backpressure; the consumer must accept it every pulse.
- A new cmd_valid during a burst is not accepted (cmd_ready=0). It is held by the source.
- **Reset:** all outputs 0 (PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, done, wd_ready). cmd_ready=1 after reset release (IDLE).
- **Reset mid-burst:** the FSM returns to IDLE asynchronously and PSEL/PENABLE drop immediately. The remaining beats are discarded, with no rsp_valid and no done.

## Timing
- Read burst, command accepted at edge E0:
  - SETUP in cycle E0+1, ACCESS in E0+2.
  - rsp_valid in E0+3, concurrent with the next SETUP.
  - N beats take 2N cycles.
  - done pulses in the cycle after the last ACCESS, together with the last rsp_valid.
- Write burst:
  - WAIT_DATA is at least 1 cycle, then SETUP/ACCESS.
  - With wd_valid held high, the first beat takes 3 cycles and each later beat 2 cycles.
  - done is in the cycle after the last ACCESS.
- PWDATA changes only at the edge that ends WAIT_DATA or ACCESS. It is never changed during a SETUP/ACCESS pair.
- All outputs are registered except cmd_ready and wd_ready, which are decoded from state.

## Structure
- Package `cat_apb_pkg`:
  - the state enum (IDLE, WAIT_DATA, SETUP, ACCESS)
  - default Amba_Word / Amba_Addr_Depth / Len_Width constants, shared with the recognizer interface instantiation
- Single module; no sub-module is warranted. The beat counter and address incrementer are inline.

## Test plan
- **Single read:** addr 0x010, len 0, slave returns 0xABCDEF.
  - PSEL high 2 cycles, PENABLE high 1 cycle.
  - rsp_rdata = 0xABCDEF with rsp_valid and done in the same cycle.
- **Write burst:** len 3 from 0x100, data 1,2,3,4 with wd_valid held high.
  - PADDR 0x100–0x103, PWDATA 1–4.
  - Total 9 cycles from accept to done; PWDATA stable through each SETUP/ACCESS pair.
- **Write stall:** wd_valid deasserted for 3 cycles before beat 2.
  - PSEL drops, FSM sits in WAIT_DATA.
  - Transfer resumes 2 cycles after wd_valid returns, with no duplicated or skipped beat.
- **Address wrap:** read len 1 from 0x1FFF (13-bit).
  - Second beat PADDR = 0x0000.
- **Reset mid-burst:** assert rst low during ACCESS of beat 2 of a 5-beat read.
  - PSEL/PENABLE = 0 immediately; no done.
  - cmd_ready=1 after release; the next command executes normally.
- **Command during busy:** cmd_valid held high throughout a burst.
  - Second command accepted only in the cycle after done (IDLE).
